// File: rtl/fp_normalize32.sv
`default_nettype none
// ============================================================================
//  Module      : fp_normalize32
//  Description : Three-stage pipelined normalizer for single-precision
//                arithmetic units. Takes an unnormalized intermediate
//                (sign, signed 10-bit biased exponent, MW-bit fixed-point
//                significand) and emits the packed 35-bit FP32N word used by
//                the rounding stage.
//  Ports       : clk, rst (sync, active-high), ce (global stall)
//                vld_i, sign_i, exp_i[9:0], man_i[MW-1:0], inf_i, nan_i
//                vld_o, o[34:0] {sign, exp[7:0], sig[25:0]}, ovf_o, unf_o
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_normalize32 #(
    parameter int MW = 50
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          vld_i,
    input  logic          sign_i,
    input  logic [9:0]    exp_i,
    input  logic [MW-1:0] man_i,
    input  logic          inf_i,
    input  logic          nan_i,
    output logic          vld_o,
    output logic [34:0]   o,
    output logic          ovf_o,
    output logic          unf_o
);

    localparam int c_LZW = $clog2(MW + 1);

    // Result path selected in stage 2, listed in priority order.
    localparam logic [2:0] c_P_NAN  = 3'd0;
    localparam logic [2:0] c_P_INF  = 3'd1;
    localparam logic [2:0] c_P_ZERO = 3'd2;
    localparam logic [2:0] c_P_OVF  = 3'd3;
    localparam logic [2:0] c_P_NORM = 3'd4;
    localparam logic [2:0] c_P_DEN  = 3'd5;

    // ------------------------------------------------------------------------
    // Stage 1: leading-zero count and input register
    // ------------------------------------------------------------------------
    logic [c_LZW-1:0] w_lzc;

    // Scanning upward lets the highest set bit write last, so the final
    // value reflects the most significant one. All-zero leaves MW.
    always_comb begin
        w_lzc = c_LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (man_i[i]) begin
                w_lzc = c_LZW'(MW - 1 - i);
            end
        end
    end

    logic             r1_vld;
    logic             r1_sign;
    logic [9:0]       r1_exp;
    logic [MW-1:0]    r1_man;
    logic             r1_inf;
    logic             r1_nan;
    logic [c_LZW-1:0] r1_lzc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_vld  <= 1'b0;
            r1_sign <= 1'b0;
            r1_exp  <= '0;
            r1_man  <= '0;
            r1_inf  <= 1'b0;
            r1_nan  <= 1'b0;
            r1_lzc  <= '0;
        end else if (ce) begin
            r1_vld  <= vld_i;
            r1_sign <= sign_i;
            r1_exp  <= exp_i;
            r1_man  <= man_i;
            r1_inf  <= inf_i;
            r1_nan  <= nan_i;
            r1_lzc  <= w_lzc;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: exponent adjust, path select, shift and sticky collection
    // ------------------------------------------------------------------------
    logic signed [10:0] w_exp_x;
    logic signed [10:0] w_e;
    logic        [10:0] w_rs;
    logic               w_zero;
    logic [MW-1:0]      w_mask;

    assign w_exp_x = {r1_exp[9], r1_exp};
    // Leading bit of man sits at weight 2^(1-lzc), hence +1.
    assign w_e     = w_exp_x + 11'sd1 - $signed(11'(r1_lzc));
    // Right-shift distance for the denormal path; only used when exp < 0.
    assign w_rs    = 11'd0 - w_exp_x;
    assign w_zero  = (r1_man == '0);
    // Ones over the bits that a right shift by w_rs pushes out.
    assign w_mask  = ~({MW{1'b1}} << w_rs);

    logic [2:0]    w_path;
    logic [MW-1:0] w_sh;
    logic          w_lost;

    always_comb begin
        w_path = c_P_ZERO;
        w_sh   = '0;
        w_lost = 1'b0;
        if (r1_nan) begin
            w_path = c_P_NAN;
        end else if (r1_inf) begin
            w_path = c_P_INF;
        end else if (w_zero) begin
            w_path = c_P_ZERO;
        end else if (w_e >= 11'sd255) begin
            w_path = c_P_OVF;
        end else if (w_e >= 11'sd1) begin
            w_path = c_P_NORM;
            w_sh   = r1_man << r1_lzc;
        end else begin
            w_path = c_P_DEN;
            if (!r1_exp[9]) begin
                // Here exp < lzc, so the left shift never loses a one.
                w_sh = r1_man << r1_exp[8:0];
            end else if (w_rs >= 11'(MW)) begin
                w_lost = |r1_man;
            end else begin
                w_sh   = r1_man >> w_rs;
                w_lost = |(r1_man & w_mask);
            end
        end
    end

    logic [25:0] w_sig;
    assign w_sig = {w_sh[MW-1 -: 25], w_sh[MW-26] | (|w_sh[MW-27:0]) | w_lost};

    logic [34:0] w_word;
    logic        w_ovf;
    logic        w_unf;

    always_comb begin
        w_word = '0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        case (w_path)
            c_P_NAN:  w_word = {r1_sign, 8'hFF, 26'h3000000};
            c_P_INF:  w_word = {r1_sign, 8'hFF, 26'h0000000};
            c_P_ZERO: w_word = {r1_sign, 8'h00, 26'h0000000};
            c_P_OVF: begin
                w_word = {r1_sign, 8'hFF, 26'h0000000};
                w_ovf  = 1'b1;
            end
            c_P_NORM: w_word = {r1_sign, w_e[7:0], w_sig};
            c_P_DEN: begin
                w_word = {r1_sign, 8'h00, w_sig};
                w_unf  = 1'b1;
            end
            default:  w_word = '0;
        endcase
    end

    logic        r2_vld;
    logic [34:0] r2_word;
    logic        r2_ovf;
    logic        r2_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_vld  <= 1'b0;
            r2_word <= '0;
            r2_ovf  <= 1'b0;
            r2_unf  <= 1'b0;
        end else if (ce) begin
            r2_vld  <= r1_vld;
            r2_word <= w_word;
            r2_ovf  <= w_ovf;
            r2_unf  <= w_unf;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: output register
    // ------------------------------------------------------------------------
    logic        r3_vld;
    logic [34:0] r3_word;
    logic        r3_ovf;
    logic        r3_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r3_vld  <= 1'b0;
            r3_word <= '0;
            r3_ovf  <= 1'b0;
            r3_unf  <= 1'b0;
        end else if (ce) begin
            r3_vld  <= r2_vld;
            r3_word <= r2_word;
            r3_ovf  <= r2_ovf;
            r3_unf  <= r2_unf;
        end
    end

    assign vld_o = r3_vld;
    assign o     = r3_word;
    assign ovf_o = r3_ovf;
    assign unf_o = r3_unf;

endmodule
`default_nettype wire
